// File: rtl/fmap_capture.sv
// Single-frame pixel capture buffer: records one IMG_W x IMG_W frame from a valid-qualified
// stream, tracks row/column and a running checksum, then exposes the frame on a read port.
module fmap_capture #(
  parameter  int PIX_BW       = 8,
  parameter  int IMG_W        = 28,
  parameter  int TOTAL_PIXELS = 784,
  parameter  int GAP_MAX      = 4,
  localparam int AW           = $clog2(TOTAL_PIXELS),
  localparam int SW           = PIX_BW + AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PIX_BW-1:0] i_pixel,
  input  logic              i_in_valid,
  input  logic              i_clear,
  input  logic              i_rd_en,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [PIX_BW-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_ready,
  output logic [AW-1:0]     o_row,
  output logic [AW-1:0]     o_col,
  output logic [SW-1:0]     o_checksum,
  output logic              o_err_gap,
  output logic              o_err_overrun,
  output logic [1:0]        o_state
);

  // Handshake: a pixel is transferred on every clk edge where i_in_valid=1; there is no
  // ready/backpressure, so pixels arriving outside IDLE/CAPTURE are dropped (and flagged in READY).

  localparam int GW = $clog2(GAP_MAX + 1) > 0 ? $clog2(GAP_MAX + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_READY   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     count_q;
  logic [AW-1:0]     row_q, col_q;
  logic [SW-1:0]     checksum_q;
  logic [GW-1:0]     gap_q;
  logic [PIX_BW-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              frame_done_q;
  logic              err_gap_q, err_overrun_q;

  logic              wr_en, first_pix, done, gap_err, overrun, rd_fire;
  logic [AW-1:0]     wr_addr;

  logic [PIX_BW-1:0] mem [0:TOTAL_PIXELS-1];

  always_comb begin
    state_d   = state_q;
    wr_en     = 1'b0;
    first_pix = 1'b0;
    done      = 1'b0;
    gap_err   = 1'b0;
    overrun   = 1'b0;
    rd_fire   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_in_valid) begin
          wr_en     = 1'b1;
          first_pix = 1'b1;
          if (TOTAL_PIXELS == 1) begin
            done    = 1'b1;
            state_d = S_READY;
          end else begin
            state_d = S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        if (i_in_valid) begin
          wr_en = 1'b1;
          if (count_q == AW'(TOTAL_PIXELS - 1)) begin
            done    = 1'b1;
            state_d = S_READY;
          end
        end else if (gap_q == GW'(GAP_MAX)) begin
          gap_err = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_READY: begin
        overrun = i_in_valid;
        rd_fire = i_rd_en;
      end
      default: state_d = S_IDLE;
    endcase
    // Clear overrides everything, including a pixel arriving in the same cycle.
    if (i_clear) begin
      state_d = S_IDLE;
      wr_en   = 1'b0;
      done    = 1'b0;
      gap_err = 1'b0;
      overrun = 1'b0;
      rd_fire = 1'b0;
    end
  end

  assign wr_addr = first_pix ? '0 : count_q;

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_addr] <= i_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      row_q         <= '0;
      col_q         <= '0;
      checksum_q    <= '0;
      gap_q         <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      err_gap_q     <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= done;
      rd_valid_q   <= rd_fire;
      if (rd_fire) begin
        // Out-of-range addresses still return a valid beat, with zero data.
        if (32'(i_rd_addr) < TOTAL_PIXELS) begin
          rd_data_q <= mem[i_rd_addr];
        end else begin
          rd_data_q <= '0;
        end
      end
      if (i_clear) begin
        count_q       <= '0;
        row_q         <= '0;
        col_q         <= '0;
        checksum_q    <= '0;
        gap_q         <= '0;
        err_gap_q     <= 1'b0;
        err_overrun_q <= 1'b0;
      end else begin
        if (gap_err) begin
          count_q    <= '0;
          row_q      <= '0;
          col_q      <= '0;
          checksum_q <= '0;
          gap_q      <= '0;
          err_gap_q  <= 1'b1;
        end else if (wr_en) begin
          gap_q <= '0;
          if (first_pix) begin
            count_q    <= AW'(1);
            checksum_q <= SW'(i_pixel);
            row_q      <= '0;
            col_q      <= '0;
          end else begin
            count_q    <= count_q + AW'(1);
            checksum_q <= checksum_q + SW'(i_pixel);
            if (col_q == AW'(IMG_W - 1)) begin
              col_q <= '0;
              row_q <= row_q + AW'(1);
            end else begin
              col_q <= col_q + AW'(1);
            end
          end
        end else if (state_q == S_CAPTURE) begin
          gap_q <= gap_q + GW'(1);
        end
        if (overrun) begin
          err_overrun_q <= 1'b1;
        end
      end
    end
  end

  assign o_busy        = (state_q == S_CAPTURE);
  assign o_ready       = (state_q == S_READY);
  assign o_state       = state_q;
  assign o_rd_data     = rd_data_q;
  assign o_rd_valid    = rd_valid_q;
  assign o_frame_done  = frame_done_q;
  assign o_row         = row_q;
  assign o_col         = col_q;
  assign o_checksum    = checksum_q;
  assign o_err_gap     = err_gap_q;
  assign o_err_overrun = err_overrun_q;

endmodule

// File: tb/tb_fmap_capture.sv
// Directed bench for fmap_capture: full frames, readback, gap boundary, overrun,
// clear/valid collision and reset in the middle of a frame.
module tb_fmap_capture;
  localparam int PIX_BW  = 8;
  localparam int IMG_W   = 28;
  localparam int TOTAL   = 784;
  localparam int GAP_MAX = 4;
  localparam int AW      = $clog2(TOTAL);
  localparam int SW      = PIX_BW + AW;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [PIX_BW-1:0] i_pixel = '0;
  logic              i_in_valid = 1'b0;
  logic              i_clear = 1'b0;
  logic              i_rd_en = 1'b0;
  logic [AW-1:0]     i_rd_addr = '0;
  logic [PIX_BW-1:0] o_rd_data;
  logic              o_rd_valid, o_busy, o_frame_done, o_ready;
  logic [AW-1:0]     o_row, o_col;
  logic [SW-1:0]     o_checksum;
  logic              o_err_gap, o_err_overrun;
  logic [1:0]        o_state;

  int n_checks = 0;
  int n_fail   = 0;

  fmap_capture #(
    .PIX_BW(PIX_BW), .IMG_W(IMG_W), .TOTAL_PIXELS(TOTAL), .GAP_MAX(GAP_MAX)
  ) dut (
    .clk(clk), .reset(reset), .i_pixel(i_pixel), .i_in_valid(i_in_valid),
    .i_clear(i_clear), .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_ready(o_ready), .o_row(o_row), .o_col(o_col),
    .o_checksum(o_checksum), .o_err_gap(o_err_gap), .o_err_overrun(o_err_overrun),
    .o_state(o_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_data"}, 32'(o_rd_data), 0);
    chk({tag, "_rd_valid"}, 32'(o_rd_valid), 0);
    chk({tag, "_frame_done"}, 32'(o_frame_done), 0);
    chk({tag, "_row"}, 32'(o_row), 0);
    chk({tag, "_col"}, 32'(o_col), 0);
    chk({tag, "_checksum"}, 32'(o_checksum), 0);
    chk({tag, "_err_gap"}, 32'(o_err_gap), 0);
    chk({tag, "_err_overrun"}, 32'(o_err_overrun), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_ready"}, 32'(o_ready), 0);
    chk({tag, "_state"}, 32'(o_state), 0);
  endtask

  // Streams a full frame (ramp = addr[7:0], or all 0x01) with an optional idle gap before pixel gap_at.
  task automatic send_frame(input bit ones, input int gap_at, input int gap_len,
                            output int done_cnt, output int done_idx, output int sum);
    done_cnt = 0;
    done_idx = -1;
    sum      = 0;
    for (int i = 0; i < TOTAL; i++) begin
      if (i == gap_at) begin
        i_in_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) tick();
        chk("gap_ok_busy", 32'(o_busy), 1);
        chk("gap_ok_err", 32'(o_err_gap), 0);
      end
      i_in_valid = 1'b1;
      i_pixel    = ones ? 8'h01 : 8'(i);
      sum       += int'(i_pixel);
      tick();
      if (o_frame_done) begin
        done_cnt++;
        done_idx = i;
      end
    end
    i_in_valid = 1'b0;
    tick();
    if (o_frame_done) done_cnt++;
  endtask

  // Leaves i_rd_en high so consecutive calls issue back-to-back reads.
  task automatic rd(input int addr, input int exp, input string tag);
    i_rd_en   = 1'b1;
    i_rd_addr = AW'(addr);
    tick();
    chk({tag, "_valid"}, 32'(o_rd_valid), 1);
    chk({tag, "_data"}, 32'(o_rd_data), exp);
  endtask

  task automatic chk_frame(input string tag, input int done_cnt, input int done_idx, input int sum);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_idx"}, done_idx, TOTAL - 1);
    chk({tag, "_ready"}, 32'(o_ready), 1);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_row"}, 32'(o_row), 27);
    chk({tag, "_col"}, 32'(o_col), 27);
    chk({tag, "_checksum"}, 32'(o_checksum), sum);
    chk({tag, "_err_gap"}, 32'(o_err_gap), 0);
  endtask

  initial begin
    int dcnt, didx, sum, psum;

    // Reset
    tick();
    tick();
    chk_reset_outputs("reset");
    reset = 1'b0;

    // Ramp frame; the ramp checksum is 3*32640 + (0+..+15) = 98040
    send_frame(1'b0, -1, 0, dcnt, didx, sum);
    chk("ramp_sum_model", sum, 98040);
    chk_frame("ramp", dcnt, didx, 98040);

    // Back-to-back reads, then one idle cycle
    rd(0,   8'h00, "rd_0");
    rd(27,  8'h1B, "rd_27");
    rd(28,  8'h1C, "rd_28");
    rd(783, 8'h0F, "rd_783");
    rd(800, 8'h00, "rd_800");
    i_rd_en = 1'b0;
    tick();
    chk("rd_idle_valid", 32'(o_rd_valid), 0);

    // Overrun: three extra 0xFF pixels in READY
    i_in_valid = 1'b1;
    i_pixel    = 8'hFF;
    tick();
    tick();
    tick();
    i_in_valid = 1'b0;
    tick();
    chk("ovr_flag", 32'(o_err_overrun), 1);
    chk("ovr_ready", 32'(o_ready), 1);
    chk("ovr_checksum", 32'(o_checksum), 98040);
    rd(0,   8'h00, "ovr_rd_0");
    rd(783, 8'h0F, "ovr_rd_783");
    i_rd_en = 1'b0;

    // Clear together with a valid pixel: clear wins
    i_clear    = 1'b1;
    i_in_valid = 1'b1;
    i_pixel    = 8'h55;
    tick();
    i_clear    = 1'b0;
    i_in_valid = 1'b0;
    chk("clr_state", 32'(o_state), 0);
    chk("clr_busy", 32'(o_busy), 0);
    chk("clr_ready", 32'(o_ready), 0);
    chk("clr_err_ovr", 32'(o_err_overrun), 0);
    chk("clr_err_gap", 32'(o_err_gap), 0);
    chk("clr_checksum", 32'(o_checksum), 0);
    chk("clr_row", 32'(o_row), 0);
    chk("clr_col", 32'(o_col), 0);

    // Read request outside READY is ignored
    i_rd_en   = 1'b1;
    i_rd_addr = '0;
    tick();
    i_rd_en = 1'b0;
    chk("idle_rd_valid", 32'(o_rd_valid), 0);

    // Frame of 0x01 with a legal GAP_MAX-cycle gap before pixel 100
    send_frame(1'b1, 100, GAP_MAX, dcnt, didx, sum);
    chk_frame("ones", dcnt, didx, 784);
    rd(0,   8'h01, "ones_rd_0");
    rd(100, 8'h01, "ones_rd_100");
    i_rd_en = 1'b0;

    // Rearm, then GAP_MAX+1 idle cycles after 50 pixels of 0x10
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    i_in_valid = 1'b1;
    i_pixel    = 8'h10;
    for (int i = 0; i < 50; i++) tick();
    i_in_valid = 1'b0;
    chk("gap_pre_checksum", 32'(o_checksum), 800);
    for (int g = 0; g < GAP_MAX; g++) tick();
    chk("gap_edge_busy", 32'(o_busy), 1);
    chk("gap_edge_err", 32'(o_err_gap), 0);
    tick();
    chk("gap_err_flag", 32'(o_err_gap), 1);
    chk("gap_err_state", 32'(o_state), 0);
    chk("gap_err_checksum", 32'(o_checksum), 0);
    chk("gap_err_col", 32'(o_col), 0);

    // Fresh frame starts at addr 0; continue to pixel 400 then reset
    i_in_valid = 1'b1;
    i_pixel    = 8'h2A;
    tick();
    chk("fresh_checksum", 32'(o_checksum), 42);
    chk("fresh_row", 32'(o_row), 0);
    chk("fresh_col", 32'(o_col), 0);
    chk("fresh_busy", 32'(o_busy), 1);
    chk("fresh_err_sticky", 32'(o_err_gap), 1);
    psum = 42;
    for (int i = 1; i < 400; i++) begin
      i_pixel = 8'(i);
      psum   += i % 256;
      tick();
      if (i == 28) begin
        chk("mid_row_28", 32'(o_row), 1);
        chk("mid_col_28", 32'(o_col), 0);
      end
    end
    chk("mid_row_399", 32'(o_row), 14);
    chk("mid_col_399", 32'(o_col), 7);
    chk("mid_checksum", 32'(o_checksum), psum);
    reset   = 1'b1;
    i_pixel = 8'hAA;
    tick();
    reset      = 1'b0;
    i_in_valid = 1'b0;
    chk_reset_outputs("midrst");

    // A full frame after the mid-frame reset
    send_frame(1'b0, -1, 0, dcnt, didx, sum);
    chk_frame("post_rst", dcnt, didx, 98040);
    rd(783, 8'h0F, "post_rd_783");
    rd(500, 8'hF4, "post_rd_500");
    i_rd_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
